// File: rtl/riscv_pkg.sv
// RV32I decode constants: opcodes, ALU op and immediate-format enums, NOP word.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_e;

  // alt selects SUB/SRA; SUB exists only for register-register ops
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt,
                                         input logic is_reg);
    case (funct3)
      3'd0:    alu_decode = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'd1:    alu_decode = ALU_SLL;
      3'd2:    alu_decode = ALU_SLT;
      3'd3:    alu_decode = ALU_SLTU;
      3'd4:    alu_decode = ALU_XOR;
      3'd5:    alu_decode = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake: instruction/PC with valid/ready.
interface decode_stage_if #(parameter int unsigned XLEN = 32);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_ready;

  modport master (output if_valid, output if_instr, output if_pc, input if_ready);
  modport slave  (input if_valid, input if_instr, input if_pc, output if_ready);
endinterface

// File: rtl/imm_gen.sv
// Immediate generator: instruction bits + format -> sign-extended 32-bit immediate.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, decoder, back-pressure, flush.
// Define DECODE_LOADUSE_EN to enable the internal load-use stall.
module decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  decode_stage_if.slave   fetch,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  output logic [4:0]      A1,
  output logic [4:0]      A2,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [4:0]      id_rd,
  output logic [XLEN-1:0] id_imm,
  output logic [3:0]      id_alu_op,
  output logic            id_alu_src,
  output logic            id_reg_write,
  output logic            id_mem_read,
  output logic            id_mem_write,
  output logic            id_branch,
  output logic            id_jump,
  output logic            id_illegal
);
  import riscv_pkg::*;

  logic            valid_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;

  logic            stall, capture;
  logic [6:0]      opcode;
  logic [4:0]      rd_field;
  imm_fmt_e        fmt;
  alu_op_e         alu_op;
  logic            alu_src, wr_fmt, mem_rd, mem_wr, br, jmp, ill, uses_rs2, no_rd;

  assign opcode   = instr_q[6:0];
  assign rd_field = instr_q[11:7];
  assign A1       = instr_q[19:15];
  assign A2       = instr_q[24:20];

  always_comb begin
    fmt      = FMT_R;
    alu_op   = ALU_ADD;
    alu_src  = 1'b0;
    wr_fmt   = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    br       = 1'b0;
    jmp      = 1'b0;
    ill      = 1'b0;
    uses_rs2 = 1'b0;
    no_rd    = 1'b0;
    case (opcode)
      OPC_OP: begin
        uses_rs2 = 1'b1;
        if (instr_q[31:25] != 7'h00 && instr_q[31:25] != 7'h20) begin
          ill = 1'b1;
        end else begin
          wr_fmt = 1'b1;
          alu_op = alu_decode(instr_q[14:12], instr_q[30], 1'b1);
        end
      end
      OPC_OP_IMM: begin
        fmt = FMT_I; alu_src = 1'b1; wr_fmt = 1'b1;
        alu_op = alu_decode(instr_q[14:12], instr_q[30], 1'b0);
      end
      OPC_LOAD:   begin fmt = FMT_I; alu_src = 1'b1; wr_fmt = 1'b1; mem_rd = 1'b1; end
      OPC_STORE:  begin fmt = FMT_S; alu_src = 1'b1; mem_wr = 1'b1; uses_rs2 = 1'b1; no_rd = 1'b1; end
      OPC_BRANCH: begin fmt = FMT_B; alu_op = ALU_SUB; br = 1'b1; uses_rs2 = 1'b1; no_rd = 1'b1; end
      OPC_JAL:    begin fmt = FMT_J; wr_fmt = 1'b1; jmp = 1'b1; end
      OPC_JALR:   begin fmt = FMT_I; alu_src = 1'b1; wr_fmt = 1'b1; jmp = 1'b1; end
      OPC_LUI:    begin fmt = FMT_U; alu_op = ALU_PASSB; alu_src = 1'b1; wr_fmt = 1'b1; end
      OPC_AUIPC:  begin fmt = FMT_U; alu_src = 1'b1; wr_fmt = 1'b1; end
      default:    ill = 1'b1;
    endcase
  end

  imm_gen u_imm_gen (
    .instr (instr_q[31:7]),
    .fmt   (fmt),
    .imm   (id_imm)
  );

`ifdef DECODE_LOADUSE_EN
  assign stall = valid_q && ex_mem_read && (ex_rd != '0) &&
                 ((ex_rd == A1) || ((ex_rd == A2) && uses_rs2));
`else
  logic unused_hazard;
  assign unused_hazard = ^{ex_mem_read, ex_rd, uses_rs2};
  assign stall = 1'b0;
`endif

  assign id_valid       = valid_q && !stall;
  assign fetch.if_ready = !valid_q || (ex_ready && !stall);
  assign capture        = fetch.if_valid && fetch.if_ready;

  // Control bits are qualified by valid_q so an empty stage never asserts side effects
  assign id_pc        = pc_q;
  assign id_rd        = no_rd ? 5'd0 : rd_field;
  assign id_alu_op    = alu_op;
  assign id_alu_src   = valid_q && alu_src;
  assign id_reg_write = valid_q && wr_fmt && (rd_field != '0);
  assign id_mem_read  = valid_q && mem_rd;
  assign id_mem_write = valid_q && mem_wr;
  assign id_branch    = valid_q && br;
  assign id_jump      = valid_q && jmp;
  assign id_illegal   = valid_q && ill;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (capture) begin
      valid_q <= 1'b1;
      instr_q <= fetch.if_instr;
      pc_q    <= fetch.if_pc;
    end else if (id_valid && ex_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage; checks DECODE_LOADUSE_EN behaviour when defined.
module tb_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, ex_ready, ex_mem_read;
  logic [4:0]  ex_rd;
  logic [4:0]  A1, A2, id_rd;
  logic        id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic        id_branch, id_jump, id_illegal;
  logic [31:0] id_pc, id_imm;
  logic [3:0]  id_alu_op;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  decode_stage_if #(.XLEN(32)) fi ();

  decode_stage #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch        (fi.slave),
    .flush        (flush),
    .ex_ready     (ex_ready),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .A1           (A1),
    .A2           (A2),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_rd        (id_rd),
    .id_imm       (id_imm),
    .id_alu_op    (id_alu_op),
    .id_alu_src   (id_alu_src),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_mem_write (id_mem_write),
    .id_branch    (id_branch),
    .id_jump      (id_jump),
    .id_illegal   (id_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge with execute ready
  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    fi.if_valid = 1'b1;
    fi.if_instr = instr;
    fi.if_pc    = pc;
    ex_ready    = 1'b1;
    step();
    fi.if_valid = 1'b0;
  endtask

  task automatic chk_ctrl_zero(input string tag);
    chk({tag, ".reg_write"}, 32'(id_reg_write), 32'd0);
    chk({tag, ".mem_read"},  32'(id_mem_read),  32'd0);
    chk({tag, ".mem_write"}, 32'(id_mem_write), 32'd0);
    chk({tag, ".branch"},    32'(id_branch),    32'd0);
    chk({tag, ".jump"},      32'(id_jump),      32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1; ex_mem_read = 1'b0; ex_rd = '0;
    fi.if_valid = 1'b0; fi.if_instr = '0; fi.if_pc = '0;
    step(); step();
    rst = 1'b0;

    // reset state
    chk("rst.id_valid", 32'(id_valid), 32'd0);
    chk("rst.if_ready", 32'(fi.if_ready), 32'd1);
    chk("rst.A1", 32'(A1), 32'd0);
    chk("rst.A2", 32'(A2), 32'd0);
    chk("rst.id_rd", 32'(id_rd), 32'd0);
    chk("rst.id_imm", id_imm, 32'd0);
    chk("rst.illegal", 32'(id_illegal), 32'd0);
    chk_ctrl_zero("rst");

    // addi x5,x1,-1
    offer(32'hFFF0_8293, 32'h0000_0100);
    chk("addi.id_valid", 32'(id_valid), 32'd1);
    chk("addi.A1", 32'(A1), 32'd1);
    chk("addi.id_rd", 32'(id_rd), 32'd5);
    chk("addi.id_imm", id_imm, 32'hFFFF_FFFF);
    chk("addi.reg_write", 32'(id_reg_write), 32'd1);
    chk("addi.alu_src", 32'(id_alu_src), 32'd1);
    chk("addi.alu_op", 32'(id_alu_op), 32'(ALU_ADD));
    chk("addi.id_pc", id_pc, 32'h0000_0100);
    step();
    chk("drain.id_valid", 32'(id_valid), 32'd0);

    // sw x2,8(x3)
    offer(32'h0021_A423, 32'h0000_0104);
    chk("sw.mem_write", 32'(id_mem_write), 32'd1);
    chk("sw.id_rd", 32'(id_rd), 32'd0);
    chk("sw.reg_write", 32'(id_reg_write), 32'd0);
    chk("sw.id_imm", id_imm, 32'd8);
    chk("sw.A1", 32'(A1), 32'd3);
    chk("sw.A2", 32'(A2), 32'd2);

    // beq x0,x0,-4 : B-format negative immediate, bit 0 cleared
    offer(32'hFE00_0EE3, 32'h0000_0108);
    chk("beq.branch", 32'(id_branch), 32'd1);
    chk("beq.id_imm", id_imm, 32'hFFFF_FFFC);
    chk("beq.id_rd", 32'(id_rd), 32'd0);
    chk("beq.alu_op", 32'(id_alu_op), 32'(ALU_SUB));

    // jal x1,+2048 : J-format imm[11] lives in instr[20]
    offer(32'h0010_00EF, 32'h0000_010C);
    chk("jal.jump", 32'(id_jump), 32'd1);
    chk("jal.id_imm", id_imm, 32'h0000_0800);
    chk("jal.reg_write", 32'(id_reg_write), 32'd1);
    chk("jal.id_rd", 32'(id_rd), 32'd1);

    // lui x5,0xABCDE
    offer(32'hABCD_E2B7, 32'h0000_0110);
    chk("lui.id_imm", id_imm, 32'hABCD_E000);
    chk("lui.alu_op", 32'(id_alu_op), 32'(ALU_PASSB));
    chk("lui.alu_src", 32'(id_alu_src), 32'd1);

    // add x3,x1,x2 then a load in execute targeting its sources
    offer(32'h0020_81B3, 32'h0000_0114);
    chk("add.alu_src", 32'(id_alu_src), 32'd0);
    ex_mem_read = 1'b1;
    ex_rd = 5'd0;
    #1 chk("lu.x0.id_valid", 32'(id_valid), 32'd1);
`ifdef DECODE_LOADUSE_EN
    ex_rd = 5'd2;
    #1 chk("lu.rs2.id_valid", 32'(id_valid), 32'd0);
    ex_rd = 5'd1;
    #1 chk("lu.rs1.id_valid", 32'(id_valid), 32'd0);
    chk("lu.rs1.if_ready", 32'(fi.if_ready), 32'd0);
    step();
    ex_mem_read = 1'b0;
    #1 chk("lu.resolve.id_valid", 32'(id_valid), 32'd1);
    chk("lu.resolve.id_rd", 32'(id_rd), 32'd3);
`else
    ex_rd = 5'd1;
    #1 chk("nolu.id_valid", 32'(id_valid), 32'd1);
    chk("nolu.if_ready", 32'(fi.if_ready), 32'd1);
    ex_mem_read = 1'b0;
`endif
    ex_rd = 5'd0;
    step();
    chk("add.drain", 32'(id_valid), 32'd0);

    // flush with a held instruction and a new one offered
    offer(32'h0050_0093, 32'h0000_0200);
    chk("fl.pre.id_valid", 32'(id_valid), 32'd1);
    flush = 1'b1;
    fi.if_valid = 1'b1;
    fi.if_instr = 32'h00A0_0113;
    fi.if_pc = 32'h0000_0204;
    step();
    flush = 1'b0;
    fi.if_valid = 1'b0;
    chk("fl.id_valid", 32'(id_valid), 32'd0);
    chk("fl.if_ready", 32'(fi.if_ready), 32'd1);
    chk("fl.id_rd", 32'(id_rd), 32'd0);
    step();
    chk("fl.after.id_valid", 32'(id_valid), 32'd0);

    // unknown opcode, then hold under ex_ready=0
    offer(32'h0000_007F, 32'h0000_0300);
    ex_ready = 1'b0;
    chk("ill.illegal", 32'(id_illegal), 32'd1);
    chk("ill.id_valid", 32'(id_valid), 32'd1);
    chk_ctrl_zero("ill");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold.id_valid", 32'(id_valid), 32'd1);
      chk("hold.illegal", 32'(id_illegal), 32'd1);
      chk("hold.id_pc", id_pc, 32'h0000_0300);
      chk("hold.if_ready", 32'(fi.if_ready), 32'd0);
    end
    ex_ready = 1'b1;
    step();

    // OP with funct7=0x01 (mul) is not RV32I
    offer(32'h0220_81B3, 32'h0000_0304);
    chk("mul.illegal", 32'(id_illegal), 32'd1);
    chk_ctrl_zero("mul");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
